// File: rtl/wb_ram_responder.sv
// Wishbone classic responder backed by a word-addressed on-chip RAM with byte-lane
// writes, configurable wait states and error termination for bad addresses.
module wb_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_ERR} state_e;

  localparam logic [3:0]  WS_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [32:0] BASE_33  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_33 = BASE_33 + (33'd4 << ADDR_WIDTH);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic [3:0]              sel_q, sel_d;
  logic [31:0]             dat_q, dat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [31:0]             rdat_q;

  logic                    req;
  logic                    bad_adr;
  logic [32:0]             adr_33;
  logic [ADDR_WIDTH-1:0]   req_idx;

  logic                    acc_en;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [3:0]              acc_sel;
  logic [31:0]             acc_dat;

  assign req     = wb_cyc_i & wb_stb_i;
  assign adr_33  = {1'b0, wb_adr_i};
  // 33-bit compare keeps a window ending at 2^32 from wrapping to zero
  assign bad_adr = (wb_adr_i[1:0] != 2'b00) || (adr_33 < BASE_33) || (adr_33 >= LIMIT_33);
  assign req_idx = ADDR_WIDTH'((wb_adr_i - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    acc_en  = 1'b0;
    acc_we  = we_q;
    acc_idx = idx_q;
    acc_sel = sel_q;
    acc_dat = dat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d = req_idx;
          we_d  = wb_we_i;
          sel_d = wb_sel_i;
          dat_d = wb_dat_i;
          if (bad_adr) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            // zero-wait access uses the live bus fields on the sampling edge
            acc_en  = 1'b1;
            acc_we  = wb_we_i;
            acc_idx = req_idx;
            acc_sel = wb_sel_i;
            acc_dat = wb_dat_i;
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          acc_en  = 1'b1;
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Single-port RAM with byte enables; reset only clears the read register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdat_q <= '0;
    end else if (acc_en) begin
      if (acc_we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
        end
      end else begin
        rdat_q <= mem[acc_idx];
      end
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Scoreboard bench for wb_ram_responder: three instances cover zero wait states,
// three wait states and an offset address window.
module tb_wb_ram_responder;

  localparam int unsigned WS1 = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cyc, stb;
  logic [31:0] dout_w [3];
  logic        ack_w  [3];
  logic        err_w  [3];

  typedef struct {
    int unsigned inst;
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    int unsigned exp_lat;
    logic [31:0] exp_d;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] last_rd [3];
  int unsigned ws_of   [3] = '{0, WS1, 0};
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_ws0 (
    .clk_i(clk), .rst_i(rst_i), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dout_w[0]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_ack_o(ack_w[0]), .wb_err_o(err_w[0]));

  wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS1), .BASE_ADDR(32'h0000_0000)) u_ws3 (
    .clk_i(clk), .rst_i(rst_i), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dout_w[1]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_ack_o(ack_w[1]), .wb_err_o(err_w[1]));

  wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) u_win (
    .clk_i(clk), .rst_i(rst_i), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dout_w[2]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
    .wb_ack_o(ack_w[2]), .wb_err_o(err_w[2]));

  // Expected read data tracks the last completed read per instance, since
  // writes and errors leave wb_dat_o holding its previous value.
  task automatic push_txn(input int unsigned inst, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s, input logic is_err,
                          input logic [31:0] rdval, input int unsigned extra_lat);
    txn_t t;
    t.inst = inst; t.adr = a; t.we = w; t.dat = d; t.sel = s;
    t.exp_ack = !is_err;
    t.exp_err = is_err;
    t.exp_lat = is_err ? 1 : ws_of[inst] + 1 + extra_lat;
    if (!is_err && !w) last_rd[inst] = rdval;
    t.exp_d = last_rd[inst];
    sb.push_back(t);
  endtask

  task automatic bus_xfer(input int unsigned inst, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic got_ack, output logic got_err, output logic [31:0] rd,
                          output int unsigned lat, output logic tail);
    adr = a; we = w; dat = d; sel = s;
    cyc[inst] = 1'b1; stb[inst] = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; rd = '0; lat = 0;
    while (!got_ack && !got_err && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got_ack = ack_w[inst];
      got_err = err_w[inst];
      rd      = dout_w[inst];
    end
    cyc[inst] = 1'b0; stb[inst] = 1'b0;
    @(posedge clk); #1;
    tail = ack_w[inst] | err_w[inst];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ack_w[i], err_w[i], dout_w[i]} !== 34'b0) begin
        errors++;
        $display("FAIL reset inst%0d: ack=%b err=%b dat=%h, want 0/0/00000000",
                 i, ack_w[i], err_w[i], dout_w[i]);
      end
    end
  endtask

  task automatic test_basic();
    txn_t t; logic ga, ge, tl; logic [31:0] rd; int unsigned lat;
    push_txn(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, '0, 0);
    push_txn(0, 32'h10, 1'b0, '0,           4'hF, 1'b0, 32'hDEADBEEF, 0);
    push_txn(0, 32'h14, 1'b1, 32'h0BADCAFE, 4'hF, 1'b0, '0, 0);
    push_txn(0, 32'h14, 1'b0, '0,           4'h1, 1'b0, 32'h0BADCAFE, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_xfer(t.inst, t.adr, t.we, t.dat, t.sel, ga, ge, rd, lat, tl);
      checks++;
      if ({ga, ge, 8'(lat), rd, tl} !== {t.exp_ack, t.exp_err, 8'(t.exp_lat), t.exp_d, 1'b0}) begin
        errors++;
        $display("FAIL basic adr=%h we=%b: ack/err/lat/dat/tail=%b/%b/%0d/%h/%b want %b/%b/%0d/%h/0",
                 t.adr, t.we, ga, ge, lat, rd, tl, t.exp_ack, t.exp_err, t.exp_lat, t.exp_d);
      end
    end
  endtask

  task automatic test_byte_lanes();
    txn_t t; logic ga, ge, tl; logic [31:0] rd; int unsigned lat;
    push_txn(0, 32'h10, 1'b0, '0,           4'hF, 1'b0, 32'hDEADBEEF, 0);
    push_txn(0, 32'h10, 1'b1, 32'h11223344, 4'b0101, 1'b0, '0, 0);
    push_txn(0, 32'h10, 1'b0, '0,           4'h0, 1'b0, 32'hDE22BE44, 0);
    push_txn(0, 32'h10, 1'b1, 32'h00000000, 4'h0, 1'b0, '0, 0);
    push_txn(0, 32'h10, 1'b0, '0,           4'hF, 1'b0, 32'hDE22BE44, 0);
    push_txn(0, 32'h14, 1'b1, 32'hAABBCCDD, 4'b1010, 1'b0, '0, 0);
    push_txn(0, 32'h14, 1'b0, '0,           4'hF, 1'b0, 32'hAAADCCFE, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_xfer(t.inst, t.adr, t.we, t.dat, t.sel, ga, ge, rd, lat, tl);
      checks++;
      if ({ga, ge, 8'(lat), rd, tl} !== {t.exp_ack, t.exp_err, 8'(t.exp_lat), t.exp_d, 1'b0}) begin
        errors++;
        $display("FAIL lanes adr=%h sel=%b: ack/err/lat/dat/tail=%b/%b/%0d/%h/%b want %b/%b/%0d/%h/0",
                 t.adr, t.sel, ga, ge, lat, rd, tl, t.exp_ack, t.exp_err, t.exp_lat, t.exp_d);
      end
    end
  endtask

  task automatic test_wait_states();
    txn_t t; logic ga, ge, tl; logic [31:0] rd; int unsigned lat;
    push_txn(1, 32'h0,  1'b1, 32'h89ABCDEF, 4'hF, 1'b0, '0, 0);
    push_txn(1, 32'h0,  1'b0, '0,           4'hF, 1'b0, 32'h89ABCDEF, 0);
    push_txn(1, 32'h40, 1'b1, 32'h12345678, 4'hF, 1'b0, '0, 0);
    push_txn(1, 32'h44, 1'b1, 32'h55AA55AA, 4'hF, 1'b0, '0, 0);
    push_txn(1, 32'h44, 1'b0, '0,           4'hF, 1'b0, 32'h55AA55AA, 0);
    push_txn(1, 32'h3,  1'b0, '0,           4'hF, 1'b1, '0, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_xfer(t.inst, t.adr, t.we, t.dat, t.sel, ga, ge, rd, lat, tl);
      checks++;
      if ({ga, ge, 8'(lat), rd, tl} !== {t.exp_ack, t.exp_err, 8'(t.exp_lat), t.exp_d, 1'b0}) begin
        errors++;
        $display("FAIL wait adr=%h we=%b: ack/err/lat/dat/tail=%b/%b/%0d/%h/%b want %b/%b/%0d/%h/0",
                 t.adr, t.we, ga, ge, lat, rd, tl, t.exp_ack, t.exp_err, t.exp_lat, t.exp_d);
      end
    end
  endtask

  task automatic test_window();
    txn_t t; logic ga, ge, tl; logic [31:0] rd; int unsigned lat;
    push_txn(2, 32'h1000, 1'b1, 32'h01020304, 4'hF, 1'b0, '0, 0);
    push_txn(2, 32'h2000, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, '0, 0);
    push_txn(2, 32'h0FFC, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, '0, 0);
    push_txn(2, 32'h1002, 1'b0, '0,           4'hF, 1'b1, '0, 0);
    push_txn(2, 32'h1FFC, 1'b1, 32'h0BADF00D, 4'hF, 1'b0, '0, 0);
    push_txn(2, 32'h1FFC, 1'b0, '0,           4'hF, 1'b0, 32'h0BADF00D, 0);
    push_txn(2, 32'h1000, 1'b0, '0,           4'hF, 1'b0, 32'h01020304, 0);
    push_txn(2, 32'h2000, 1'b0, '0,           4'hF, 1'b1, '0, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_xfer(t.inst, t.adr, t.we, t.dat, t.sel, ga, ge, rd, lat, tl);
      checks++;
      if ({ga, ge, 8'(lat), rd, tl} !== {t.exp_ack, t.exp_err, 8'(t.exp_lat), t.exp_d, 1'b0}) begin
        errors++;
        $display("FAIL window adr=%h we=%b: ack/err/lat/dat/tail=%b/%b/%0d/%h/%b want %b/%b/%0d/%h/0",
                 t.adr, t.we, ga, ge, lat, rd, tl, t.exp_ack, t.exp_err, t.exp_lat, t.exp_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    txn_t t; logic got; int unsigned n;
    push_txn(0, 32'h10, 1'b0, '0,           4'hF, 1'b0, 32'hDE22BE44, 0);
    push_txn(0, 32'h20, 1'b1, 32'hA5A50F0F, 4'hF, 1'b0, '0, 1);
    push_txn(0, 32'h20, 1'b0, '0,           4'hF, 1'b0, 32'hA5A50F0F, 1);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      adr = t.adr; we = t.we; dat = t.dat; sel = t.sel;
      got = 1'b0; n = 0;
      while (!got && n < 10) begin
        @(posedge clk); #1;
        n++;
        got = ack_w[0];
      end
      checks++;
      if ({got, err_w[0], 8'(n), dout_w[0]} !== {1'b1, 1'b0, 8'(t.exp_lat), t.exp_d}) begin
        errors++;
        $display("FAIL b2b adr=%h we=%b: ack/err/lat/dat=%b/%b/%0d/%h want 1/0/%0d/%h",
                 t.adr, t.we, got, err_w[0], n, dout_w[0], t.exp_lat, t.exp_d);
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    txn_t t; logic ga, ge, tl; logic [31:0] rd; int unsigned lat; logic seen;
    adr = 32'h40; we = 1'b1; dat = 32'hCAFEF00D; sel = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | ack_w[1] | err_w[1];
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | ack_w[1] | err_w[1];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort pulse: ack|err seen=%b want 0", seen);
    end
    push_txn(1, 32'h40, 1'b0, '0, 4'hF, 1'b0, 32'h12345678, 0);
    t = sb.pop_front();
    bus_xfer(t.inst, t.adr, t.we, t.dat, t.sel, ga, ge, rd, lat, tl);
    checks++;
    if ({ga, ge, 8'(lat), rd, tl} !== {t.exp_ack, t.exp_err, 8'(t.exp_lat), t.exp_d, 1'b0}) begin
      errors++;
      $display("FAIL abort readback: ack/err/lat/dat/tail=%b/%b/%0d/%h/%b want %b/%b/%0d/%h/0",
               ga, ge, lat, rd, tl, t.exp_ack, t.exp_err, t.exp_lat, t.exp_d);
    end
  endtask

  task automatic test_reset_on_access();
    txn_t t; logic ga, ge, tl; logic [31:0] rd; int unsigned lat; logic seen;
    adr = 32'h10; we = 1'b1; dat = 32'h00000000; sel = 4'hF;
    cyc[0] = 1'b1; stb[0] = 1'b1; rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    seen = ack_w[0] | err_w[0];
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | ack_w[0] | err_w[0];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_edge pulse: ack|err seen=%b want 0", seen);
    end
    push_txn(0, 32'h10, 1'b0, '0, 4'hF, 1'b0, 32'hDE22BE44, 0);
    t = sb.pop_front();
    bus_xfer(t.inst, t.adr, t.we, t.dat, t.sel, ga, ge, rd, lat, tl);
    checks++;
    if ({ga, ge, 8'(lat), rd, tl} !== {t.exp_ack, t.exp_err, 8'(t.exp_lat), t.exp_d, 1'b0}) begin
      errors++;
      $display("FAIL rst_edge readback: ack/err/lat/dat/tail=%b/%b/%0d/%h/%b want %b/%b/%0d/%h/0",
               ga, ge, lat, rd, tl, t.exp_ack, t.exp_err, t.exp_lat, t.exp_d);
    end
  endtask

  task automatic test_reset_in_wait();
    txn_t t; logic ga, ge, tl; logic [31:0] rd; int unsigned lat; logic seen;
    push_txn(1, 32'h44, 1'b0, '0, 4'hF, 1'b0, 32'h55AA55AA, 0);
    t = sb.pop_front();
    bus_xfer(t.inst, t.adr, t.we, t.dat, t.sel, ga, ge, rd, lat, tl);
    checks++;
    if ({ga, rd} !== {1'b1, t.exp_d}) begin
      errors++;
      $display("FAIL rst_wait preload: ack/dat=%b/%h want 1/%h", ga, rd, t.exp_d);
    end
    adr = 32'h44; we = 1'b1; dat = 32'hFFFFFFFF; sel = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    checks++;
    if ({ack_w[1], err_w[1], dout_w[1]} !== 34'b0) begin
      errors++;
      $display("FAIL rst_wait outputs: ack=%b err=%b dat=%h want 0/0/00000000",
               ack_w[1], err_w[1], dout_w[1]);
    end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | ack_w[1] | err_w[1];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait pulse: ack|err seen=%b want 0", seen);
    end
    push_txn(1, 32'h44, 1'b0, '0, 4'hF, 1'b0, 32'h55AA55AA, 0);
    t = sb.pop_front();
    bus_xfer(t.inst, t.adr, t.we, t.dat, t.sel, ga, ge, rd, lat, tl);
    checks++;
    if ({ga, ge, 8'(lat), rd, tl} !== {t.exp_ack, t.exp_err, 8'(t.exp_lat), t.exp_d, 1'b0}) begin
      errors++;
      $display("FAIL rst_wait readback: ack/err/lat/dat/tail=%b/%b/%0d/%h/%b want %b/%b/%0d/%h/0",
               ga, ge, lat, rd, tl, t.exp_ack, t.exp_err, t.exp_lat, t.exp_d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    adr = '0; dat = '0; sel = '0; we = 1'b0;
    cyc = '0; stb = '0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_states();
    test_window();
    test_back_to_back();
    test_abort();
    test_reset_on_access();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
